// File: rtl/double_buffer_pkg.sv
// Definitions shared by the producer- and consumer-side double-buffer sequencers:
// sequencer state encoding and the frame-size limit.
package double_buffer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } sequencerState;

  // Largest frame a buffer of the given address width can describe.
  function automatic int maxFrameWords(input int addressWidth);
    return (1 << addressWidth) - 1;
  endfunction

  localparam int DEFAULT_ADDRESS_WIDTH = 8;
  localparam int MAX_FRAME_WORDS       = maxFrameWords(DEFAULT_ADDRESS_WIDTH);

endpackage

// File: rtl/stream_skid_buffer.sv
// Two-entry valid/ready skid buffer. Head entry drives the output; a flush
// empties it in one cycle without touching the stored words.
module stream_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             flush,
  output logic [WIDTH-1:0] outData,
  output logic             outValid,
  input  logic             outReady,
  output logic [1:0]       occupancy
);

  logic [WIDTH-1:0] entry0Reg;
  logic [WIDTH-1:0] entry1Reg;
  logic [1:0]       countReg;
  logic             pop;
  logic             accept;
  logic [1:0]       writeIndex;

  assign pop        = outValid && outReady;
  // Slot the incoming word lands in after this cycle's pop has shifted the queue.
  assign writeIndex = countReg - {1'b0, pop};
  assign accept     = push && (writeIndex < 2'd2);

  assign outData   = entry0Reg;
  assign outValid  = (countReg != 2'd0);
  assign occupancy = countReg;

  always_ff @(posedge clock) begin
    if (reset) begin
      entry0Reg <= '0;
      entry1Reg <= '0;
      countReg  <= 2'd0;
    end else if (flush) begin
      countReg <= 2'd0;
    end else begin
      if (accept && writeIndex == 2'd0) begin
        entry0Reg <= pushData;
      end else if (pop) begin
        entry0Reg <= entry1Reg;
      end
      if (accept && writeIndex == 2'd1) begin
        entry1Reg <= pushData;
      end
      countReg <= countReg + {1'b0, accept} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/double_buffer_reader.sv
// Consumer-side sequencer: latches a published frame length, walks the read
// pointer through the buffer's one-cycle read port and streams the words out.
module double_buffer_reader
  import double_buffer_pkg::*;
#(
  parameter int DATA_WIDTH    = 10,
  parameter int ADDRESS_WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     newData,
  input  logic [ADDRESS_WIDTH-1:0] dataLength,
  output logic [ADDRESS_WIDTH-1:0] readPointer,
  input  logic [DATA_WIDTH-1:0]    dataOut,
  output logic [DATA_WIDTH-1:0]    streamData,
  output logic                     streamValid,
  input  logic                     streamReady,
  output logic                     streamLast,
  output logic                     busy,
  output logic                     overrun
);

  localparam logic [ADDRESS_WIDTH-1:0] ADDRESS_ONE = ADDRESS_WIDTH'(1);

  sequencerState            stateReg;
  logic [ADDRESS_WIDTH-1:0] lengthReg;
  logic [ADDRESS_WIDTH-1:0] issueCountReg;
  logic [ADDRESS_WIDTH-1:0] readPointerReg;
  logic                     inFlightReg;
  logic                     inFlightLastReg;
  logic                     busyReg;
  logic                     overrunReg;

  logic [1:0]               stored;
  logic                     pop;
  logic                     abort;
  logic                     issue;
  logic                     lastIssue;
  logic [2:0]               projected;
  logic [DATA_WIDTH:0]      headWord;

  assign pop   = streamValid && streamReady;
  assign abort = newData && (stateReg != IDLE);

  // Words that will sit in the skid buffer once this cycle's pop and the
  // in-flight capture settle; issuing only below 2 guarantees no overflow.
  assign projected = {1'b0, stored} + {2'b00, inFlightReg} - {2'b00, pop};
  assign issue     = (stateReg == READ) && (issueCountReg < lengthReg) && (projected < 3'd2);
  assign lastIssue = (issueCountReg == lengthReg - ADDRESS_ONE);

  always_ff @(posedge clock) begin
    if (reset) begin
      stateReg        <= IDLE;
      lengthReg       <= '0;
      issueCountReg   <= '0;
      readPointerReg  <= '0;
      inFlightReg     <= 1'b0;
      inFlightLastReg <= 1'b0;
      busyReg         <= 1'b0;
      overrunReg      <= 1'b0;
    end else begin
      overrunReg  <= abort;
      inFlightReg <= issue && !abort;
      if (issue) begin
        inFlightLastReg <= lastIssue;
      end

      if (abort) begin
        stateReg <= LATCH;
        busyReg  <= 1'b1;
      end else begin
        case (stateReg)
          IDLE: begin
            if (newData) begin
              stateReg <= LATCH;
              busyReg  <= 1'b1;
            end
          end
          LATCH: begin
            lengthReg      <= dataLength;
            issueCountReg  <= '0;
            readPointerReg <= '0;
            if (dataLength == '0) begin
              stateReg <= IDLE;
              busyReg  <= 1'b0;
            end else begin
              stateReg <= READ;
            end
          end
          READ: begin
            if (issue) begin
              issueCountReg <= issueCountReg + ADDRESS_ONE;
              // The pointer parks on the final address instead of stepping past it.
              if (lastIssue) begin
                stateReg <= DRAIN;
              end else begin
                readPointerReg <= readPointerReg + ADDRESS_ONE;
              end
            end
          end
          DRAIN: begin
            if (!inFlightReg && stored == {1'b0, pop}) begin
              stateReg <= IDLE;
              busyReg  <= 1'b0;
            end
          end
          default: begin
            stateReg <= IDLE;
            busyReg  <= 1'b0;
          end
        endcase
      end
    end
  end

  stream_skid_buffer #(
    .WIDTH(DATA_WIDTH + 1)
  ) outputStage (
    .clock    (clock),
    .reset    (reset),
    .push     (inFlightReg),
    .pushData ({inFlightLastReg, dataOut}),
    .flush    (abort),
    .outData  (headWord),
    .outValid (streamValid),
    .outReady (streamReady),
    .occupancy(stored)
  );

  assign streamData  = headWord[DATA_WIDTH-1:0];
  assign streamLast  = headWord[DATA_WIDTH];
  assign readPointer = readPointerReg;
  assign busy        = busyReg;
  assign overrun     = overrunReg;

endmodule

// File: tb/tb_double_buffer_reader.sv
// Randomised bench for double_buffer_reader against a frame-level queue model.
module tb_double_buffer_reader;

  localparam int DW = 10;
  localparam int AW = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          newData;
  logic [AW-1:0] dataLength;
  logic [AW-1:0] readPointer;
  logic [DW-1:0] dataOut;
  logic [DW-1:0] streamData;
  logic          streamValid;
  logic          streamReady;
  logic          streamLast;
  logic          busy;
  logic          overrun;

  logic [DW-1:0] mem [256];

  always #5 clock = ~clock;

  // Buffer read port: one cycle of latency.
  always @(posedge clock) dataOut <= mem[readPointer];

  double_buffer_reader #(
    .DATA_WIDTH   (DW),
    .ADDRESS_WIDTH(AW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .newData    (newData),
    .dataLength (dataLength),
    .readPointer(readPointer),
    .dataOut    (dataOut),
    .streamData (streamData),
    .streamValid(streamValid),
    .streamReady(streamReady),
    .streamLast (streamLast),
    .busy       (busy),
    .overrun    (overrun)
  );

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } streamWord;

  int checks     = 0;
  int failures   = 0;
  int cycleCount = 0;

  streamWord expQueue[$];
  int        xferCycles[$];
  bit        active      = 1'b0;
  bit        latchCycle  = 1'b0;
  bit        overrunExp  = 1'b0;
  bit        holdPrev    = 1'b0;
  logic [DW-1:0] prevData = '0;
  logic      prevLast    = 1'b0;
  int        curLen      = 0;
  int        readyMode   = 0;
  bit        toggleReady = 1'b0;

  task automatic checkValue(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, actual, expected, cycleCount);
    end
  endtask

  // Frame-level reference: expected words, busy window and overrun pulses.
  task automatic modelStep();
    bit        nextActive;
    bit        nextLatch;
    bit        nextOverrun;
    streamWord expWord;
    nextActive  = active;
    nextLatch   = 1'b0;
    nextOverrun = 1'b0;
    if (reset) begin
      active     = 1'b0;
      latchCycle = 1'b0;
      overrunExp = 1'b0;
      holdPrev   = 1'b0;
      expQueue.delete();
    end else begin
      checkValue("busy", 32'(busy), 32'(active));
      checkValue("overrun", 32'(overrun), 32'(overrunExp));
      if (overrunExp) checkValue("flushValid", 32'(streamValid), 0);
      if (!active) checkValue("idleValid", 32'(streamValid), 0);
      if (active && !latchCycle && curLen > 0)
        checkValue("pointerRange", 32'(int'(readPointer) <= curLen - 1), 1);
      if (holdPrev && !overrunExp) begin
        checkValue("holdValid", 32'(streamValid), 1);
        checkValue("holdData", 32'(streamData), 32'(prevData));
        checkValue("holdLast", 32'(streamLast), 32'(prevLast));
      end
      if (streamValid && streamReady) begin
        if (expQueue.size() == 0) begin
          checkValue("extraWord", 32'(streamValid), 0);
        end else begin
          expWord = expQueue.pop_front();
          checkValue("data", 32'(streamData), 32'(expWord.data));
          checkValue("last", 32'(streamLast), 32'(expWord.last));
          xferCycles.push_back(cycleCount);
          if (expWord.last) nextActive = 1'b0;
        end
      end
      if (latchCycle) begin
        curLen = int'(dataLength);
        for (int i = 0; i < curLen; i++) begin
          streamWord w;
          w.last = (i == curLen - 1);
          w.data = mem[8'(i)];
          expQueue.push_back(w);
        end
        if (curLen == 0) nextActive = 1'b0;
      end
      if (newData) begin
        nextOverrun = active;
        expQueue.delete();
        nextActive  = 1'b1;
        nextLatch   = 1'b1;
      end
      holdPrev   = streamValid && !streamReady;
      prevData   = streamData;
      prevLast   = streamLast;
      active     = nextActive;
      latchCycle = nextLatch;
      overrunExp = nextOverrun;
    end
  endtask

  task automatic runCycle(input bit pulse, input bit rst);
    @(posedge clock);
    #1;
    newData = pulse;
    reset   = rst;
    case (readyMode)
      0: streamReady = 1'b1;
      1: begin
        toggleReady = !toggleReady;
        streamReady = toggleReady;
      end
      2: streamReady = 1'($urandom);
      default: streamReady = 1'b0;
    endcase
    @(negedge clock);
    modelStep();
    cycleCount++;
  endtask

  task automatic loadFrame(input int len);
    for (int i = 0; i < 256; i++) mem[8'(i)] = 10'($urandom);
    dataLength = 8'(len);
  endtask

  task automatic waitFrameDone(input int limit);
    int n;
    n = 0;
    while ((active || expQueue.size() != 0) && n < limit) begin
      runCycle(1'b0, 1'b0);
      n++;
    end
    if (n >= limit) checkValue("frameTimeout", 32'(busy), 0);
    $display("frame len=%0d transfers=%0d ended cycle %0d", curLen, xferCycles.size(), cycleCount);
    runCycle(1'b0, 1'b0);
    runCycle(1'b0, 1'b0);
  endtask

  task automatic runUntilQueue(input int remaining, input int limit);
    int n;
    n = 0;
    while (expQueue.size() != remaining && n < limit) begin
      runCycle(1'b0, 1'b0);
      n++;
    end
    if (n >= limit) checkValue("queueTimeout", 32'(expQueue.size()), 32'(remaining));
  endtask

  initial begin
    int start;
    reset       = 1'b1;
    newData     = 1'b0;
    dataLength  = '0;
    streamReady = 1'b1;
    for (int i = 0; i < 256; i++) mem[8'(i)] = '0;

    repeat (3) runCycle(1'b0, 1'b1);
    runCycle(1'b0, 1'b0);
    checkValue("resetPointer", 32'(readPointer), 0);
    checkValue("resetData", 32'(streamData), 0);
    checkValue("resetValid", 32'(streamValid), 0);
    checkValue("resetLast", 32'(streamLast), 0);
    checkValue("resetBusy", 32'(busy), 0);
    checkValue("resetOverrun", 32'(overrun), 0);

    // Single frame, ready high: words 10..14 on cycles 4..8 after newData.
    readyMode = 0;
    loadFrame(5);
    for (int i = 0; i < 5; i++) mem[8'(i)] = 10'(10 + i);
    xferCycles.delete();
    start = cycleCount;
    runCycle(1'b1, 1'b0);
    waitFrameDone(50);
    checkValue("singleCount", 32'(xferCycles.size()), 5);
    for (int i = 0; i < xferCycles.size(); i++)
      checkValue("singleLatency", 32'(xferCycles[i] - start), 32'(4 + i));

    // Zero-length frame.
    loadFrame(0);
    xferCycles.delete();
    runCycle(1'b1, 1'b0);
    waitFrameDone(20);
    checkValue("zeroCount", 32'(xferCycles.size()), 0);

    // Backpressure: ready toggles every cycle.
    readyMode = 1;
    loadFrame(8);
    xferCycles.delete();
    runCycle(1'b1, 1'b0);
    waitFrameDone(200);
    checkValue("backpressureCount", 32'(xferCycles.size()), 8);

    // Overrun: new length-3 frame while word 2 of a length-10 frame is pending.
    readyMode = 0;
    loadFrame(10);
    runCycle(1'b1, 1'b0);
    runUntilQueue(8, 50);
    readyMode = 3;
    loadFrame(3);
    runCycle(1'b1, 1'b0);
    readyMode = 0;
    xferCycles.delete();
    waitFrameDone(50);
    checkValue("overrunNewCount", 32'(xferCycles.size()), 3);

    // Maximum frame under random backpressure.
    readyMode = 2;
    loadFrame(255);
    xferCycles.delete();
    runCycle(1'b1, 1'b0);
    waitFrameDone(3000);
    checkValue("maxCount", 32'(xferCycles.size()), 255);

    // Reset together with newData at word 4 of 10.
    readyMode = 0;
    loadFrame(10);
    runCycle(1'b1, 1'b0);
    runUntilQueue(6, 50);
    dataLength = 8'd5;
    runCycle(1'b1, 1'b1);
    runCycle(1'b0, 1'b0);
    checkValue("midResetPointer", 32'(readPointer), 0);
    checkValue("midResetData", 32'(streamData), 0);
    checkValue("midResetValid", 32'(streamValid), 0);
    checkValue("midResetLast", 32'(streamLast), 0);
    checkValue("midResetBusy", 32'(busy), 0);
    checkValue("midResetOverrun", 32'(overrun), 0);
    runCycle(1'b0, 1'b0);
    checkValue("midResetNoLatch", 32'(busy), 0);
    $display("reset mid-frame applied at cycle %0d", cycleCount);

    // Random frames under random backpressure.
    readyMode = 2;
    repeat (6) begin
      loadFrame(int'($urandom_range(1, 40)));
      xferCycles.delete();
      runCycle(1'b1, 1'b0);
      waitFrameDone(500);
      checkValue("randomCount", 32'(xferCycles.size()), 32'(curLen));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/double_buffer_reader.md
# double_buffer_reader

Consumer-side sequencer for the double buffer. On each `newData` pulse it latches the published frame length, walks the read pointer from 0 to length-1 through the buffer's one-cycle-latency read port, and emits the words as a valid/ready stream with a last-word marker. It sits in the read clock domain between the double buffer and the downstream packetiser or UART, and gives the producer side a `busy` indication.

## Interface
Parameters:
- `DATA_WIDTH`, default 10: word width; must match the buffer.
- `ADDRESS_WIDTH`, default 8: buffer address width. Maximum frame is 2^ADDRESS_WIDTH - 1 words.

Ports:
- `clock`  in  1  single clock, the buffer's read clock.
- `reset`  in  1  synchronous, active-high.
- `newData`  in  1  one-cycle pulse from the buffer: a new frame is published.
- `dataLength`  in  ADDRESS_WIDTH  frame length from the buffer. Valid from the cycle after `newData`.
- `readPointer`  out  ADDRESS_WIDTH  buffer read address.
- `dataOut`  in  DATA_WIDTH  buffer read data, equal to mem[readPointer of the previous cycle].
- `streamData`  out  DATA_WIDTH  output word.
- `streamValid`  out  1  output word valid.
- `streamReady`  in  1  downstream accepts; a transfer occurs when valid && ready.
- `streamLast`  out  1  qualifies the word at index length-1.
- `busy`  out  1  high in every state except IDLE.
- `overrun`  out  1  one-cycle pulse when a new frame aborts an unfinished one.

## Operation
- **States:** IDLE, LATCH, READ, DRAIN.
- **IDLE:**
  - `newData` -> LATCH.
- **LATCH** (1 cycle):
  - Sample `dataLength` into `length`.
  - Clear `issueCount`.
  - Set `readPointer` to 0.
  - If length == 0 -> IDLE, with no output. Otherwise -> READ.
- **READ:**
  - Issue rule: an issue occurs in a cycle when issueCount < length and (stored + inFlight - pop) < 2.
    - `stored` is the skid-buffer occupancy, 0..2.
    - `inFlight` is 1 if the previous cycle issued.
    - `pop` is valid && ready.
  - On issue, the word at `readPointer` is captured from `dataOut` on the next cycle. Then `readPointer` and `issueCount` increment.
  - When issueCount reaches length -> DRAIN.
- **DRAIN:**
  - When inFlight == 0 and stored == 0 -> IDLE.
- **Output stage:** a 2-entry skid buffer. Each entry carries data and a last flag.
  - Last flag = (index == length-1).
  - `streamData` and `streamLast` come from the head entry. `streamValid` = stored != 0.
  - Once `streamValid` is high it holds, with stable data, until accepted. The only exceptions are overrun and reset.
- **Overrun:** `newData` arrives in LATCH, READ or DRAIN.
  - Next cycle: `overrun` pulses for 1 cycle.
  - The skid buffer and in-flight word are flushed, so `streamValid` is low that cycle.
  - The FSM goes to LATCH for the new frame.
  - The aborted frame never shows `streamLast`.
- **Width and arithmetic:**
  - Counters are ADDRESS_WIDTH wide. No wrap, since length ≤ 2^ADDRESS_WIDTH - 1.
  - `readPointer` never exceeds length-1 while issuing. When stalled it holds its last value.

## Timing
- **Reset values:**
  - FSM in IDLE.
  - `readPointer` = 0, `streamData` = 0.
  - `streamValid`, `streamLast`, `busy` and `overrun` = 0.
  - Skid buffer empty.
  - Reset overrides every other event in the same cycle, including `newData`.
- **Latency:** with `newData` at cycle 0:
  - LATCH in cycle 1.
  - First issue (address 0) in cycle 2.
  - `dataOut` valid in cycle 3.
  - First `streamValid` in cycle 4.
- **Throughput:** with `streamReady` held high, one word per cycle. A frame of N words finishes its last transfer at cycle N+3. IDLE and `busy` = 0 follow on the next cycle.
- **`busy`:** rises the cycle after `newData` and falls the cycle after the final transfer.
- **Backpressure:** with `streamReady` low, at most 2 words are buffered and issuing stalls. Deasserting `streamReady` for k cycles delays completion by exactly k cycles.
- **Reset mid-frame:** outputs return to reset values the following cycle. No `overrun` pulse.

## Structure
- **Shared package `double_buffer_pkg`:**
  - FSM state encodings (IDLE=0, LATCH=1, READ=2, DRAIN=3).
  - The max-frame constant 2^ADDRESS_WIDTH - 1.
  - It is shared with the producer-side sequencer.
- **Sub-module `stream_skid_buffer`:**
  - Parameterised width and depth 2.
  - Ports: push, pushData, flush, valid/ready out.
  - Reused by other stream blocks.
- **This module:** the FSM, counters, issue rule and overrun detection.

## Test plan
- **Single frame, ready always high:** length=5, memory 10..14. Required:
  - Words 10,11,12,13,14 on consecutive cycles 4..8.
  - `streamLast` only with 14.
  - `busy` high cycles 1..8.
- **Zero length:** `newData` with length=0. Required:
  - Never `streamValid`.
  - `busy` high for exactly 1 cycle.
  - No `overrun`.
- **Backpressure:** length=8, `streamReady` toggled 1/0 each cycle. Required:
  - All 8 words in order, no duplicates or drops.
  - Data stable while valid && !ready.
  - `readPointer` never exceeds 7.
- **Overrun:** second `newData` (length=3) while word 2 of a length-10 frame is pending. Required:
  - `overrun` pulses once.
  - `streamValid` goes low.
  - The new frame delivers its 3 words with `streamLast` on the third.
- **Maximum frame:** length=255. Required:
  - 255 transfers, addresses 0..254.
  - `streamLast` on index 254.
  - No pointer wrap.
- **Reset mid-frame:** reset asserted at word 4 of 10, together with `newData`. Required:
  - All outputs at reset values the next cycle.
  - IDLE, with no LATCH entered.
